// File: rtl/pool1_feature_buffer_if.sv
// Handshake bundle between the pool1 stage, the feature buffer and its window reader.
interface pool1_feature_buffer_if #(
    parameter int WIDTH = 8,
    parameter int WIN   = 5
);
    logic                    clear;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_ch0;
    logic signed [WIDTH-1:0] in_ch1;
    logic signed [WIDTH-1:0] in_ch2;
    logic signed [WIDTH-1:0] in_ch3;
    logic                    in_done;
    logic                    rd_req;
    logic [1:0]              rd_ch;
    logic [8:0]              rd_base;
    logic                    rd_valid;
    logic [WIN*WIDTH-1:0]    rd_data;
    logic                    rd_ready;
    logic [9:0]              frame_len;
    logic                    full;
    logic                    overflow;

    modport master (
        output clear, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_done,
        output rd_req, rd_ch, rd_base,
        input  rd_valid, rd_data, rd_ready, frame_len, full, overflow
    );

    modport slave (
        input  clear, in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_done,
        input  rd_req, rd_ch, rd_base,
        output rd_valid, rd_data, rd_ready, frame_len, full, overflow
    );
endinterface

// File: rtl/pool1_feature_buffer.sv
// Frame buffer for pooled 4-channel vectors: fills one frame, then serves
// zero-padded WIN-sample windows from a selected channel, one per cycle.
module pool1_feature_buffer #(
    parameter int DEPTH = 500,
    parameter int WIDTH = 8,
    parameter int WIN   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pool1_feature_buffer_if.slave  bus
);
    localparam logic [0:0] FILL    = 1'b0;
    localparam logic [0:0] READY   = 1'b1;
    localparam logic [9:0] DEPTH_L = 10'(DEPTH);

    logic [0:0]           state_q, state_d;
    logic [8:0]           wr_ptr_q, wr_ptr_d;
    logic [9:0]           frame_len_q, frame_len_d;
    logic                 overflow_q, overflow_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [WIN*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIN*WIDTH-1:0] win;
    logic [9:0]           idx;
    logic                 wr_en;

    logic [WIDTH-1:0]     mem [4][DEPTH];
    logic [3:0][WIDTH-1:0] in_vec;

    assign in_vec = {bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0};

    // Window gather; indices past the stored frame read as zero, no wrap.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 0; k < WIN; k++) begin
            idx = {1'b0, bus.rd_base} + 10'(k);
            if (idx < frame_len_q)
                win[k*WIDTH +: WIDTH] = mem[bus.rd_ch][idx[8:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        wr_en       = 1'b0;
        if (bus.clear) begin
            state_d     = FILL;
            wr_ptr_d    = '0;
            frame_len_d = '0;
            overflow_d  = 1'b0;
        end else if (state_q == FILL) begin
            if (bus.in_valid) begin
                wr_en       = 1'b1;
                wr_ptr_d    = wr_ptr_q + 9'd1;
                frame_len_d = frame_len_q + 10'd1;
                if (frame_len_q == DEPTH_L - 10'd1)
                    state_d = READY;
            end
            // A vector arriving with in_done is still stored above.
            if (bus.in_done)
                state_d = READY;
        end else begin
            if (bus.in_valid)
                overflow_d = 1'b1;
            if (bus.rd_req) begin
                rd_valid_d = 1'b1;
                rd_data_d  = win;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            frame_len_q <= '0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            frame_len_q <= frame_len_d;
            overflow_q  <= overflow_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int c = 0; c < 4; c++)
                mem[c][wr_ptr_q] <= in_vec[c];
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_ready  = (state_q == READY);
    assign bus.frame_len = frame_len_q;
    assign bus.full      = (frame_len_q == DEPTH_L);
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pool1_feature_buffer.sv
// Directed bench for pool1_feature_buffer with a read-window scoreboard.
module tb_pool1_feature_buffer;
    localparam int DEPTH = 500;
    localparam int WIDTH = 8;
    localparam int WIN   = 5;
    localparam int DW    = WIN * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0]    sb_q[$];
    logic [WIDTH-1:0] model [4][DEPTH];
    int               m_len = 0;
    bit               m_ready = 1'b0;

    pool1_feature_buffer_if #(.WIDTH(WIDTH), .WIN(WIN)) bus ();

    pool1_feature_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rd_valid pulse consumes one expected window.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!rst && bus.rd_valid) begin
            if (sb_q.size() == 0)
                chk("unexpected_rd_valid", 64'd1, 64'd0);
            else begin
                e = sb_q.pop_front();
                chk("rd_data", 64'(bus.rd_data), 64'(e));
            end
        end
    end

    function automatic logic [DW-1:0] pk5(input int a, input int b, input int c, input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [DW-1:0] exp_win(input int ch, input int base);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < WIN; k++)
            if (base + k < m_len) r[k*WIDTH +: WIDTH] = model[ch][base+k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int a, input int b, input int c, input int d);
        bus.in_valid = 1'b1;
        bus.in_ch0 = 8'(a);
        bus.in_ch1 = 8'(b);
        bus.in_ch2 = 8'(c);
        bus.in_ch3 = 8'(d);
        if (!m_ready && m_len < DEPTH) begin
            model[0][m_len] = 8'(a);
            model[1][m_len] = 8'(b);
            model[2][m_len] = 8'(c);
            model[3][m_len] = 8'(d);
            m_len++;
            if (m_len == DEPTH) m_ready = 1'b1;
        end
    endtask

    task automatic rd_issue(input int ch, input int base, input logic [DW-1:0] exp);
        bus.rd_req  = 1'b1;
        bus.rd_ch   = 2'(ch);
        bus.rd_base = 9'(base);
        sb_q.push_back(exp);
        tick();
        chk("rd_latency", 64'(bus.rd_valid), 64'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_valid"},  64'(bus.rd_valid),  64'd0);
        chk({tag, "_rd_data"},   64'(bus.rd_data),   64'd0);
        chk({tag, "_rd_ready"},  64'(bus.rd_ready),  64'd0);
        chk({tag, "_frame_len"}, 64'(bus.frame_len), 64'd0);
        chk({tag, "_full"},      64'(bus.full),      64'd0);
        chk({tag, "_overflow"},  64'(bus.overflow),  64'd0);
    endtask

    initial begin
        bus.clear = 0; bus.in_valid = 0; bus.in_done = 0; bus.rd_req = 0;
        bus.in_ch0 = 0; bus.in_ch1 = 0; bus.in_ch2 = 0; bus.in_ch3 = 0;
        bus.rd_ch = 0; bus.rd_base = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_rd_ready", 64'(bus.rd_ready), 64'd0);

        // Read attempt while filling must be ignored.
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        chk("fill_rd_ignored", 64'(bus.rd_valid), 64'd0);

        // Full frame, back-to-back vectors.
        for (int i = 0; i < DEPTH; i++) begin
            drive_vec(i, i + 1, i + 2, i + 3);
            tick();
            if (i == DEPTH - 2) begin
                chk("len_499", 64'(bus.frame_len), 64'd499);
                chk("not_ready_499", 64'(bus.rd_ready), 64'd0);
            end
        end
        bus.in_valid = 1'b0;
        chk("full_after_500", 64'(bus.full), 64'd1);
        chk("ready_after_500", 64'(bus.rd_ready), 64'd1);
        chk("len_500", 64'(bus.frame_len), 64'd500);

        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
        chk("done_in_ready_len", 64'(bus.frame_len), 64'd500);
        chk("done_in_ready_state", 64'(bus.rd_ready), 64'd1);

        // Consecutive window reads.
        rd_issue(2, 10, pk5(12, 13, 14, 15, 16));
        rd_issue(0, 498, pk5(242, 243, 0, 0, 0));
        rd_issue(0, 500, pk5(0, 0, 0, 0, 0));
        rd_issue(1, 100, exp_win(1, 100));
        rd_issue(3, 495, exp_win(3, 495));
        bus.rd_req = 1'b0;
        tick();
        chk("rd_valid_drop", 64'(bus.rd_valid), 64'd0);
        repeat (3) tick();
        chk("rd_data_hold", 64'(bus.rd_data), 64'(exp_win(3, 495)));

        // Vector offered in READY is dropped.
        drive_vec(9, 9, 9, 9);
        tick();
        bus.in_valid = 1'b0;
        chk("overflow_set", 64'(bus.overflow), 64'd1);
        chk("overflow_len", 64'(bus.frame_len), 64'd500);
        rd_issue(0, 0, pk5(0, 1, 2, 3, 4));
        bus.rd_req = 1'b0;
        tick();

        // clear outranks in_valid and rd_req.
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ch0 = 8'd77;
        bus.rd_req = 1'b1;
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.rd_req = 1'b0;
        m_len = 0; m_ready = 1'b0;
        chk("clear_rd_ready", 64'(bus.rd_ready), 64'd0);
        chk("clear_len", 64'(bus.frame_len), 64'd0);
        chk("clear_overflow", 64'(bus.overflow), 64'd0);
        chk("clear_full", 64'(bus.full), 64'd0);
        chk("clear_rd_valid", 64'(bus.rd_valid), 64'd0);

        // Short frame; the last vector arrives together with in_done.
        for (int i = 0; i < 6; i++) begin
            drive_vec(i, i + 1, i + 2, i + 3);
            tick();
        end
        drive_vec(6, 7, 8, 9);
        bus.in_done = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_done = 1'b0;
        m_ready = 1'b1;
        chk("short_ready", 64'(bus.rd_ready), 64'd1);
        chk("short_len", 64'(bus.frame_len), 64'd7);
        chk("short_full", 64'(bus.full), 64'd0);
        rd_issue(1, 511, pk5(0, 0, 0, 0, 0));
        rd_issue(1, 5, pk5(6, 7, 0, 0, 0));
        bus.rd_req = 1'b0;
        tick();

        // Async reset midway through a frame.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_len = 0; m_ready = 1'b0;
        for (int i = 0; i < 250; i++) begin
            drive_vec(i + 100, i + 101, i + 102, i + 103);
            tick();
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        m_len = 0; m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            drive_vec(i * 3 + 50, i * 3 + 51, i * 3 + 52, i * 3 + 53);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("refill_full", 64'(bus.full), 64'd1);
        chk("refill_len", 64'(bus.frame_len), 64'd500);
        rd_issue(3, 0, pk5(53, 56, 59, 62, 65));
        rd_issue(0, 0, pk5(50, 53, 56, 59, 62));
        rd_issue(2, 250, exp_win(2, 250));
        bus.rd_req = 1'b0;
        repeat (2) tick();

        chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
